// File: rtl/vga_line_buffer.sv
// Double-banked 480-pixel line buffer: a 16-bit word writer fills one bank while the reader serialises the other.
// Optional VGA_LINEBUF_STATUS_EN adds the saturating err_count port.
module vga_line_buffer #(
  parameter int unsigned WORD_W         = 16,
  parameter int unsigned WORDS_PER_LINE = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              wr_ready,
  input  logic              line_start,
  input  logic              pix_en,
  output logic              pixel,
  output logic              underrun,
  output logic              overflow,
  input  logic              clr_flags
`ifdef VGA_LINEBUF_STATUS_EN
  ,
  output logic [7:0]        err_count
`endif
);

  localparam int unsigned PTR_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [PTR_W-1:0] WORD_LAST = PTR_W'(WORDS_PER_LINE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_W - 1);

  typedef enum logic {IDLE, SCAN} rd_state_t;

  logic [WORD_W-1:0] r_mem [2][WORDS_PER_LINE];
  logic [1:0]        r_full;
  logic              r_wr_sel;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic              r_rd_sel;
  logic [PTR_W-1:0]  r_rd_word;
  logic [BIT_W-1:0]  r_rd_bit;
  rd_state_t         r_state;
  logic              r_pixel;
  logic              r_underrun;
  logic              r_overflow;

  logic              w_wr_accept;
  logic              w_wr_reject;
  logic              w_wr_last;
  logic              w_scan_last;
  logic              w_release;
  logic              w_start_sel;
  logic              w_start_ok;
  logic              w_underrun_ev;
  logic              w_rd_bit_val;
  logic [1:0]        w_full_nxt;

  assign wr_ready = ~r_full[r_wr_sel];
  assign pixel    = r_pixel;
  assign underrun = r_underrun;
  assign overflow = r_overflow;

  always_comb begin
    w_wr_accept   = wr_en & wr_ready;
    w_wr_reject   = wr_en & ~wr_ready;
    w_wr_last     = w_wr_accept && (r_wr_ptr == WORD_LAST);
    w_scan_last   = (r_state == SCAN) && pix_en && !line_start &&
                    (r_rd_word == WORD_LAST) && (r_rd_bit == BIT_LAST);
    w_release     = (r_state == SCAN) && (line_start || w_scan_last);
    // An aborted scan hands over to the other bank before the new line is judged.
    w_start_sel   = (r_state == SCAN) ? ~r_rd_sel : r_rd_sel;
    w_start_ok    = r_full[w_start_sel];
    w_underrun_ev = line_start && !w_start_ok;
    w_rd_bit_val  = r_mem[r_rd_sel][r_rd_word][r_rd_bit];
    w_full_nxt    = r_full;
    if (w_release) w_full_nxt[r_rd_sel] = 1'b0;
    if (w_wr_last) w_full_nxt[r_wr_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_wr_accept) r_mem[r_wr_sel][r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full     <= '0;
      r_wr_sel   <= 1'b0;
      r_wr_ptr   <= '0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr_accept) begin
        if (w_wr_last) begin
          r_wr_ptr <= '0;
          r_wr_sel <= ~r_wr_sel;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end
      if (w_underrun_ev)  r_underrun <= 1'b1;
      else if (clr_flags) r_underrun <= 1'b0;
      if (w_wr_reject)    r_overflow <= 1'b1;
      else if (clr_flags) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rd_sel  <= 1'b0;
      r_rd_word <= '0;
      r_rd_bit  <= '0;
      r_pixel   <= 1'b0;
    end else if (line_start) begin
      r_pixel   <= 1'b0;
      r_rd_sel  <= w_start_sel;
      r_rd_word <= '0;
      r_rd_bit  <= '0;
      r_state   <= w_start_ok ? SCAN : IDLE;
    end else if (pix_en) begin
      if (r_state == SCAN) begin
        r_pixel <= w_rd_bit_val;
        if (r_rd_bit == BIT_LAST) begin
          r_rd_bit <= '0;
          if (r_rd_word == WORD_LAST) begin
            r_rd_word <= '0;
            r_rd_sel  <= ~r_rd_sel;
            r_state   <= IDLE;
          end else begin
            r_rd_word <= r_rd_word + 1'b1;
          end
        end else begin
          r_rd_bit <= r_rd_bit + 1'b1;
        end
      end else begin
        r_pixel <= 1'b0;
      end
    end
  end

`ifdef VGA_LINEBUF_STATUS_EN
  logic [7:0] r_err_count;
  logic [1:0] w_err_inc;
  logic [8:0] w_err_sum;

  assign err_count = r_err_count;

  always_comb begin
    w_err_inc = {1'b0, w_underrun_ev} + {1'b0, w_wr_reject};
    w_err_sum = {1'b0, (clr_flags ? 8'd0 : r_err_count)} + {7'd0, w_err_inc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_err_count <= '0;
    else if (w_err_sum[8]) r_err_count <= 8'hFF;
    else                 r_err_count <= w_err_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_vga_line_buffer.sv
// Directed self-checking bench for vga_line_buffer; err_count checks only when VGA_LINEBUF_STATUS_EN is defined.
module tb_vga_line_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        wr_ready;
  logic        line_start = 1'b0;
  logic        pix_en = 1'b0;
  logic        pixel;
  logic        underrun;
  logic        overflow;
  logic        clr_flags = 1'b0;
`ifdef VGA_LINEBUF_STATUS_EN
  logic [7:0]  err_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_line_buffer #(.WORD_W(16), .WORDS_PER_LINE(30)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .wr_ready(wr_ready),
    .line_start(line_start), .pix_en(pix_en), .pixel(pixel), .underrun(underrun),
    .overflow(overflow), .clr_flags(clr_flags)
`ifdef VGA_LINEBUF_STATUS_EN
    , .err_count(err_count)
`endif
  );

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic write_line(input logic [15:0] w0, input logic [15:0] rest);
    for (int k = 0; k < 30; k++) begin
      wr_en = 1'b1; wr_data = (k == 0) ? w0 : rest;
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic do_line_start;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    checks++; if (pixel !== 1'b0) begin failures++; $display("FAIL reset_pixel got=%b exp=0", pixel); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`ifdef VGA_LINEBUF_STATUS_EN
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_line;
    logic exp;
    write_line(16'h0001, 16'h0000);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL single_wr_ready_after_fill got=%b exp=1", wr_ready); end
    do_line_start();
    checks++; if (pixel !== 1'b0) begin failures++; $display("FAIL single_pixel_after_start got=%b exp=0", pixel); end
    for (int i = 0; i < 480; i++) begin
      pix_en = 1'b1;
      @(negedge clk);
      exp = (i == 0);
      checks++; if (pixel !== exp) begin failures++; $display("FAIL single_pix[%0d] got=%b exp=%b", i, pixel, exp); end
    end
    pix_en = 1'b0;
    @(negedge clk);
    checks++; if (pixel !== 1'b0) begin failures++; $display("FAIL single_pixel_hold got=%b exp=0", pixel); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL single_wr_ready_after_line got=%b exp=1", wr_ready); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL single_no_underrun got=%b exp=0", underrun); end
    do_line_start();
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL single_banks_empty_underrun got=%b exp=1", underrun); end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL single_clr_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_pattern;
    logic [15:0] pat [30];
    logic [15:0] w;
    logic exp;
    for (int k = 0; k < 30; k++) pat[k] = 16'h1357 + 16'(k) * 16'h0F21;
    for (int k = 0; k < 30; k++) begin
      wr_en = 1'b1; wr_data = pat[k];
      @(negedge clk);
    end
    wr_en = 1'b0;
    do_line_start();
    for (int i = 0; i < 480; i++) begin
      pix_en = 1'b1;
      @(negedge clk);
      w = pat[i / 16];
      exp = w[i % 16];
      checks++; if (pixel !== exp) begin failures++; $display("FAIL pattern_pix[%0d] got=%b exp=%b", i, pixel, exp); end
    end
    pix_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overflow;
    for (int k = 0; k < 60; k++) begin
      wr_en = 1'b1; wr_data = (k < 30) ? 16'hFFFF : 16'h0000;
      @(negedge clk);
      if (k == 29) begin
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL ovf_ready_after_30 got=%b exp=1", wr_ready); end
      end
    end
    wr_en = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL ovf_ready_after_60 got=%b exp=0", wr_ready); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before_reject got=%b exp=0", overflow); end
    wr_en = 1'b1; wr_data = 16'h0000;
    @(negedge clk);
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
`ifdef VGA_LINEBUF_STATUS_EN
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL ovf_err_count got=%0d exp=1", err_count); end
`endif
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
  endtask

  task automatic test_back_to_back_abort;
    do_line_start();
    for (int i = 0; i < 100; i++) begin
      pix_en = 1'b1;
      @(negedge clk);
      checks++; if (pixel !== 1'b1) begin failures++; $display("FAIL abortA_pix[%0d] got=%b exp=1", i, pixel); end
    end
    pix_en = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL abort_ready_before got=%b exp=0", wr_ready); end
    do_line_start();
    checks++; if (pixel !== 1'b0) begin failures++; $display("FAIL abort_pixel_cleared got=%b exp=0", pixel); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL abort_ready_after got=%b exp=1", wr_ready); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL abort_no_underrun got=%b exp=0", underrun); end
    for (int i = 0; i < 480; i++) begin
      pix_en = 1'b1;
      @(negedge clk);
      checks++; if (pixel !== 1'b0) begin failures++; $display("FAIL abortB_pix[%0d] got=%b exp=0", i, pixel); end
    end
    pix_en = 1'b0;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL abort_ready_end got=%b exp=1", wr_ready); end
  endtask

  task automatic test_underrun;
    line_start = 1'b1; clr_flags = 1'b1;
    @(negedge clk);
    line_start = 1'b0; clr_flags = 1'b0;
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL underrun_set_beats_clr got=%b exp=1", underrun); end
    for (int i = 0; i < 480; i++) begin
      pix_en = 1'b1;
      @(negedge clk);
      checks++; if (pixel !== 1'b0) begin failures++; $display("FAIL underrun_pix[%0d] got=%b exp=0", i, pixel); end
    end
    pix_en = 1'b0;
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_clr got=%b exp=0", underrun); end
    // The writer's bank equals an unchanged read bank, so this line must be found.
    write_line(16'h0003, 16'h0000);
    do_line_start();
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL underrun_rd_sel_kept got=%b exp=0", underrun); end
    for (int i = 0; i < 2; i++) begin
      pix_en = 1'b1;
      @(negedge clk);
      checks++; if (pixel !== 1'b1) begin failures++; $display("FAIL underrun_next_line_pix[%0d] got=%b exp=1", i, pixel); end
    end
    pix_en = 1'b0;
  endtask

  task automatic test_same_cycle;
    write_line(16'h0001, 16'hFFFF);
    checks++; if (pixel !== 1'b1) begin failures++; $display("FAIL same_pixel_hold got=%b exp=1", pixel); end
    line_start = 1'b1; pix_en = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    checks++; if (pixel !== 1'b0) begin failures++; $display("FAIL same_cycle_pixel got=%b exp=0", pixel); end
    @(negedge clk);
    checks++; if (pixel !== 1'b1) begin failures++; $display("FAIL same_first_bit got=%b exp=1", pixel); end
    @(negedge clk);
    checks++; if (pixel !== 1'b0) begin failures++; $display("FAIL same_second_bit got=%b exp=0", pixel); end
    @(negedge clk);
    pix_en = 1'b0;
    checks++; if (pixel !== 1'b0) begin failures++; $display("FAIL same_third_bit got=%b exp=0", pixel); end
  endtask

  task automatic test_reset_mid_scan;
    pix_en = 1'b1;
    repeat (198) @(negedge clk);
    pix_en = 1'b0;
    checks++; if (pixel !== 1'b1) begin failures++; $display("FAIL mid_pixel200 got=%b exp=1", pixel); end
    for (int k = 0; k < 5; k++) begin
      wr_en = 1'b1; wr_data = 16'hFFFF;
      @(negedge clk);
    end
    wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pixel !== 1'b0) begin failures++; $display("FAIL async_reset_pixel got=%b exp=0", pixel); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL async_reset_wr_ready got=%b exp=1", wr_ready); end
    checks++; if (underrun !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL async_reset_flags got=%b%b exp=00", underrun, overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_line_start();
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL post_reset_underrun got=%b exp=1", underrun); end
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    checks++; if (pixel !== 1'b0) begin failures++; $display("FAIL post_reset_black got=%b exp=0", pixel); end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_pattern();
    test_overflow();
    test_back_to_back_abort();
    test_underrun();
    test_same_cycle();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
